// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer.
//   state_t  : sequencer state encoding (idle, trap flush/redirect, mret flush/redirect)
//   CauseW   : width of the exception cause code carried into mcause
//   IrqCause : mcause value written for a machine timer interrupt
package trap_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTFlush,
        StTRedir,
        StRFlush,
        StRRedir
    } state_t;

    localparam int unsigned CauseW   = 4;
    localparam logic [31:0] IrqCause = 32'h8000_0007;

endpackage

// File: rtl/trap_sequencer.sv
// Trap sequencer: turns an exception, timer interrupt or MRET seen in the XB stage into a
// flush / PC-redirect sequence and produces the mepc/mcause/mtval CSR write strobe.
//
// Optional feature macro: TRAP_SEQUENCER_IRQ_EN adds the machine timer interrupt path and
// the MIE/MPIE mstatus bits.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   XB_bubble, XB_pc               XB stage valid (inverted) and its PC
//   initiate_exception, exc_cause, exc_tval   exception request and its cause/trap value
//   mret                           XB instruction is MRET
//   csr_mtvec, csr_mepc            current trap vector and return PC
//   redirect_ready                 fetch accepts the redirect this cycle
//   irq_timer, irq_enable          (IRQ_EN only) timer interrupt request and enable
//   flush, stall                   pipeline kill / fetch freeze
//   redirect_valid, redirect_pc    PC redirect request
//   trap_we, trap_mepc, trap_mcause, trap_mtval   CSR write strobe and data
//   trap_count                     saturating count of traps taken
//   mstatus_mie                    (IRQ_EN only) current MIE bit
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              XB_bubble,
    input  logic [31:0]       XB_pc,
    input  logic              initiate_exception,
    input  logic [CauseW-1:0] exc_cause,
    input  logic [31:0]       exc_tval,
    input  logic              mret,
    input  logic [31:0]       csr_mtvec,
    input  logic [31:0]       csr_mepc,
    input  logic              redirect_ready,
`ifdef TRAP_SEQUENCER_IRQ_EN
    input  logic              irq_timer,
    input  logic              irq_enable,
    output logic              mstatus_mie,
`endif
    output logic              flush,
    output logic              stall,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              trap_we,
    output logic [31:0]       trap_mepc,
    output logic [31:0]       trap_mcause,
    output logic [31:0]       trap_mtval,
    output logic [CNT_W-1:0]  trap_count
);

    state_t           state_q, state_d;
    logic [31:0]      mepc_q, mcause_q, mtval_q, redir_pc_q;
    logic [CNT_W-1:0] count_q;

    logic accept, take_exc, take_mret, take_irq, take_trap;

    // Redirect targets are word aligned; the low PC bits are intentionally dropped.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{csr_mtvec[1:0], csr_mepc[1:0]};

    assign accept    = (state_q == StIdle) && !XB_bubble;
    assign take_exc  = accept && initiate_exception;
    assign take_mret = accept && !initiate_exception && mret;

`ifdef TRAP_SEQUENCER_IRQ_EN
    logic mie_q, mpie_q;

    assign take_irq = accept && !initiate_exception && !mret && irq_timer && irq_enable && mie_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b1;
        end else if (take_trap) begin
            mpie_q <= mie_q;
            mie_q  <= 1'b0;
        end else if (take_mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end
    end

    assign mstatus_mie = mie_q;
`else
    assign take_irq = 1'b0;
`endif

    assign take_trap = take_exc || take_irq;

    // Control outputs decode straight from state so an asynchronous reset clears them
    // immediately, without waiting for a clock edge.
    always_comb begin
        state_d        = state_q;
        flush          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        trap_we        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (take_trap) begin
                    state_d = StTFlush;
                end else if (take_mret) begin
                    state_d = StRFlush;
                end
            end
            StTFlush: begin
                flush   = 1'b1;
                stall   = 1'b1;
                trap_we = 1'b1;
                state_d = StTRedir;
            end
            StRFlush: begin
                flush   = 1'b1;
                stall   = 1'b1;
                state_d = StRRedir;
            end
            StTRedir, StRRedir: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            redir_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;

            if (take_exc) begin
                mepc_q   <= XB_pc;
                mcause_q <= {{(32 - CauseW){1'b0}}, exc_cause};
                mtval_q  <= exc_tval;
            end else if (take_irq) begin
                mepc_q   <= XB_pc;
                mcause_q <= IrqCause;
                mtval_q  <= '0;
            end

            // mepc is captured at MRET acceptance; mtvec is sampled on the way into the
            // trap redirect and then held while fetch back-pressures.
            if (take_mret) begin
                redir_pc_q <= {csr_mepc[31:2], 2'b00};
            end else if (state_q == StTFlush) begin
                redir_pc_q <= {csr_mtvec[31:2], 2'b00};
            end

            if (take_trap && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign redirect_pc = redir_pc_q;
    assign trap_mepc   = mepc_q;
    assign trap_mcause = mcause_q;
    assign trap_mtval  = mtval_q;
    assign trap_count  = count_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer (small trap_count width so saturation is reachable).
module tb_trap_sequencer;

    localparam int unsigned CntW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            XB_bubble;
    logic [31:0]     XB_pc;
    logic            initiate_exception;
    logic [3:0]      exc_cause;
    logic [31:0]     exc_tval;
    logic            mret;
    logic [31:0]     csr_mtvec;
    logic [31:0]     csr_mepc;
    logic            redirect_ready;
    logic            flush, stall, redirect_valid, trap_we;
    logic [31:0]     redirect_pc, trap_mepc, trap_mcause, trap_mtval;
    logic [CntW-1:0] trap_count;
`ifdef TRAP_SEQUENCER_IRQ_EN
    logic            irq_timer;
    logic            irq_enable;
    logic            mstatus_mie;
`endif

    trap_sequencer #(.CNT_W(CntW)) dut (
        .clk                (clk),
        .reset              (reset),
        .XB_bubble          (XB_bubble),
        .XB_pc              (XB_pc),
        .initiate_exception (initiate_exception),
        .exc_cause          (exc_cause),
        .exc_tval           (exc_tval),
        .mret               (mret),
        .csr_mtvec          (csr_mtvec),
        .csr_mepc           (csr_mepc),
        .redirect_ready     (redirect_ready),
`ifdef TRAP_SEQUENCER_IRQ_EN
        .irq_timer          (irq_timer),
        .irq_enable         (irq_enable),
        .mstatus_mie        (mstatus_mie),
`endif
        .flush              (flush),
        .stall              (stall),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .trap_we            (trap_we),
        .trap_mepc          (trap_mepc),
        .trap_mcause        (trap_mcause),
        .trap_mtval         (trap_mtval),
        .trap_count         (trap_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        trap;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] pc;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad = 0;
    logic [CntW-1:0] exp_count = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_count();
        if (exp_count != {CntW{1'b1}}) exp_count = exp_count + 1'b1;
    endtask

    task automatic idle_inputs();
        XB_bubble          = 1'b1;
        initiate_exception = 1'b0;
        mret               = 1'b0;
`ifdef TRAP_SEQUENCER_IRQ_EN
        irq_timer          = 1'b0;
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({flush, stall, redirect_valid, trap_we} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {flush, stall, redirect_valid, trap_we});
        end
        total++;
        if ({redirect_pc, trap_mepc, trap_mcause, trap_mtval} !== 128'h0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h %h want all 0",
                     redirect_pc, trap_mepc, trap_mcause, trap_mtval);
        end
        total++;
        if (trap_count !== '0) begin
            bad++;
            $display("FAIL reset_count: got %0d want 0", trap_count);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_exception();
        exp_t e, got;
        e = '{trap: 1'b1, mepc: 32'h100, mcause: 32'h2, mtval: 32'hDEAD, pc: 32'h204};
        step();
        XB_bubble = 1'b0; XB_pc = 32'h100; initiate_exception = 1'b1;
        exc_cause = 4'd2; exc_tval = 32'hDEAD; csr_mtvec = 32'h204; redirect_ready = 1'b1;
        sb.push_back(e);
        bump_count();
        step();
        idle_inputs();
        @(negedge clk);
        got = sb.pop_front();
        total++;
        if ({flush, stall, trap_we, redirect_valid} !== {2'b11, got.trap, 1'b0}) begin
            bad++;
            $display("FAIL exc_tflush_ctrl: got %b want %b",
                     {flush, stall, trap_we, redirect_valid}, {2'b11, got.trap, 1'b0});
        end
        total++;
        if (trap_mepc !== got.mepc) begin
            bad++;
            $display("FAIL exc_mepc: got %h want %h", trap_mepc, got.mepc);
        end
        total++;
        if (trap_mcause !== got.mcause) begin
            bad++;
            $display("FAIL exc_mcause: got %h want %h", trap_mcause, got.mcause);
        end
        total++;
        if (trap_mtval !== got.mtval) begin
            bad++;
            $display("FAIL exc_mtval: got %h want %h", trap_mtval, got.mtval);
        end
        @(negedge clk);
        total++;
        if ({redirect_valid, stall, flush, trap_we, redirect_pc} !== {4'b1100, got.pc}) begin
            bad++;
            $display("FAIL exc_redir: got v=%b s=%b f=%b we=%b pc=%h want 1 1 0 0 %h",
                     redirect_valid, stall, flush, trap_we, redirect_pc, got.pc);
        end
        @(negedge clk);
        total++;
        if ({flush, stall, redirect_valid, trap_we} !== 4'b0000) begin
            bad++;
            $display("FAIL exc_idle: got %b want 0000", {flush, stall, redirect_valid, trap_we});
        end
        total++;
        if (trap_count !== exp_count) begin
            bad++;
            $display("FAIL exc_count: got %0d want %0d", trap_count, exp_count);
        end
    endtask

    task automatic test_mret();
        exp_t e, got;
        e = '{trap: 1'b0, mepc: 32'h0, mcause: 32'h0, mtval: 32'h0, pc: 32'h100};
        step();
        XB_bubble = 1'b0; mret = 1'b1; csr_mepc = 32'h103; redirect_ready = 1'b1;
        sb.push_back(e);
        step();
        idle_inputs();
        @(negedge clk);
        got = sb.pop_front();
        total++;
        if ({flush, stall, trap_we, redirect_valid} !== {2'b11, got.trap, 1'b0}) begin
            bad++;
            $display("FAIL mret_rflush_ctrl: got %b want %b",
                     {flush, stall, trap_we, redirect_valid}, {2'b11, got.trap, 1'b0});
        end
        @(negedge clk);
        total++;
        if ({redirect_valid, flush, trap_we, redirect_pc} !== {3'b100, got.pc}) begin
            bad++;
            $display("FAIL mret_redir: got v=%b f=%b we=%b pc=%h want 1 0 0 %h",
                     redirect_valid, flush, trap_we, redirect_pc, got.pc);
        end
        @(negedge clk);
        total++;
        if ({flush, stall, redirect_valid, trap_count} !== {3'b000, exp_count}) begin
            bad++;
            $display("FAIL mret_idle: got ctrl=%b cnt=%0d want 000 cnt=%0d",
                     {flush, stall, redirect_valid}, trap_count, exp_count);
        end
    endtask

    task automatic test_priority();
        exp_t e, got;
        e = '{trap: 1'b1, mepc: 32'h200, mcause: 32'h5, mtval: 32'h77, pc: 32'h300};
        step();
        XB_bubble = 1'b0; XB_pc = 32'h200; initiate_exception = 1'b1; mret = 1'b1;
        exc_cause = 4'd5; exc_tval = 32'h77; csr_mtvec = 32'h301; csr_mepc = 32'h800;
        sb.push_back(e);
        bump_count();
        step();
        idle_inputs();
        @(negedge clk);
        got = sb.pop_front();
        total++;
        if ({trap_we, trap_mepc, trap_mcause} !== {got.trap, got.mepc, got.mcause}) begin
            bad++;
            $display("FAIL prio_trap: got we=%b mepc=%h mcause=%h want %b %h %h",
                     trap_we, trap_mepc, trap_mcause, got.trap, got.mepc, got.mcause);
        end
        @(negedge clk);
        total++;
        if ({redirect_valid, redirect_pc} !== {1'b1, got.pc}) begin
            bad++;
            $display("FAIL prio_redir: got v=%b pc=%h want 1 %h",
                     redirect_valid, redirect_pc, got.pc);
        end
        @(negedge clk);
        total++;
        if (trap_count !== exp_count) begin
            bad++;
            $display("FAIL prio_count: got %0d want %0d", trap_count, exp_count);
        end
    endtask

    task automatic test_bubble();
        step();
        XB_bubble = 1'b1; initiate_exception = 1'b1; mret = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({flush, stall, trap_we, redirect_valid} !== 4'b0000) begin
                bad++;
                $display("FAIL bubble_ignore[%0d]: got %b want 0000", i,
                         {flush, stall, trap_we, redirect_valid});
            end
        end
        step();
        idle_inputs();
        @(negedge clk);
        total++;
        if (trap_count !== exp_count) begin
            bad++;
            $display("FAIL bubble_count: got %0d want %0d", trap_count, exp_count);
        end
    endtask

    task automatic test_back_to_back_ignored();
        exp_t e, got;
        e = '{trap: 1'b1, mepc: 32'h400, mcause: 32'h3, mtval: 32'h1, pc: 32'h500};
        step();
        XB_bubble = 1'b0; XB_pc = 32'h400; initiate_exception = 1'b1;
        exc_cause = 4'd3; exc_tval = 32'h1; csr_mtvec = 32'h500; redirect_ready = 1'b0;
        sb.push_back(e);
        bump_count();
        step();
        idle_inputs();
        @(negedge clk);
        got = sb.pop_front();
        total++;
        if ({trap_we, trap_mepc} !== {got.trap, got.mepc}) begin
            bad++;
            $display("FAIL bp_tflush: got we=%b mepc=%h want %b %h",
                     trap_we, trap_mepc, got.trap, got.mepc);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            // New requests and a moving mtvec while fetch is stalled must not disturb the redirect.
            XB_bubble = 1'b0; initiate_exception = 1'b1; mret = 1'b1; exc_cause = 4'd9;
            XB_pc = 32'hBAD0; csr_mtvec = 32'h999;
            @(negedge clk);
            total++;
            if ({redirect_valid, stall, flush, trap_we, redirect_pc} !== {4'b1100, got.pc}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b s=%b f=%b we=%b pc=%h want 1 1 0 0 %h", i,
                         redirect_valid, stall, flush, trap_we, redirect_pc, got.pc);
            end
        end
        step();
        idle_inputs();
        redirect_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({redirect_valid, redirect_pc} !== {1'b1, got.pc}) begin
            bad++;
            $display("FAIL bp_release: got v=%b pc=%h want 1 %h", redirect_valid, redirect_pc, got.pc);
        end
        @(negedge clk);
        total++;
        if ({flush, stall, redirect_valid, trap_we, trap_count, trap_mepc} !==
            {4'b0000, exp_count, got.mepc}) begin
            bad++;
            $display("FAIL bp_idle: got ctrl=%b cnt=%0d mepc=%h want 0000 cnt=%0d mepc=%h",
                     {flush, stall, redirect_valid, trap_we}, trap_count, trap_mepc,
                     exp_count, got.mepc);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, got;
        e = '{trap: 1'b1, mepc: 32'h900, mcause: 32'h7, mtval: 32'h11, pc: 32'hA00};
        step();
        XB_bubble = 1'b0; XB_pc = 32'h900; initiate_exception = 1'b1;
        exc_cause = 4'd7; exc_tval = 32'h11; csr_mtvec = 32'hA00; redirect_ready = 1'b0;
        sb.push_back(e);
        bump_count();
        step();
        idle_inputs();
        @(negedge clk);
        got = sb.pop_front();
        @(negedge clk);
        total++;
        if ({redirect_valid, redirect_pc} !== {1'b1, got.pc}) begin
            bad++;
            $display("FAIL rstmid_redir: got v=%b pc=%h want 1 %h", redirect_valid, redirect_pc, got.pc);
        end
        #2;
        reset = 1'b1;
        exp_count = '0;
        #1;
        total++;
        if ({flush, stall, redirect_valid, trap_we, redirect_pc, trap_mepc, trap_mcause,
             trap_mtval, trap_count} !== '0) begin
            bad++;
            $display("FAIL rstmid_clear: got ctrl=%b pc=%h mepc=%h mcause=%h mtval=%h cnt=%0d want all 0",
                     {flush, stall, redirect_valid, trap_we}, redirect_pc, trap_mepc,
                     trap_mcause, trap_mtval, trap_count);
        end
        step();
        reset = 1'b0;
        redirect_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({flush, stall, redirect_valid, trap_we} !== 4'b0000) begin
                bad++;
                $display("FAIL rstmid_no_pending[%0d]: got %b want 0000", i,
                         {flush, stall, redirect_valid, trap_we});
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            step();
            XB_bubble = 1'b0; XB_pc = 32'h1000 + i; initiate_exception = 1'b1;
            exc_cause = 4'd1; exc_tval = 32'h0; csr_mtvec = 32'h40; redirect_ready = 1'b1;
            bump_count();
            step();
            idle_inputs();
            step();
            step();
            @(negedge clk);
            total++;
            if (trap_count !== exp_count) begin
                bad++;
                $display("FAIL sat_count[%0d]: got %0d want %0d", i, trap_count, exp_count);
            end
        end
    endtask

`ifdef TRAP_SEQUENCER_IRQ_EN
    task automatic test_irq();
        exp_t e, got;
        @(negedge clk);
        total++;
        if (mstatus_mie !== 1'b0) begin
            bad++;
            $display("FAIL irq_mie_reset: got %b want 0", mstatus_mie);
        end
        // mret with MPIE=1 enables interrupts.
        step();
        XB_bubble = 1'b0; mret = 1'b1; csr_mepc = 32'h40; redirect_ready = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        @(negedge clk);
        total++;
        if (mstatus_mie !== 1'b1) begin
            bad++;
            $display("FAIL irq_mie_after_mret: got %b want 1", mstatus_mie);
        end
        step();
        XB_bubble = 1'b0; irq_timer = 1'b1; irq_enable = 1'b0;
        @(negedge clk);
        total++;
        if (flush !== 1'b0) begin
            bad++;
            $display("FAIL irq_disabled: got flush=%b want 0", flush);
        end
        e = '{trap: 1'b1, mepc: 32'h600, mcause: 32'h8000_0007, mtval: 32'h0, pc: 32'h700};
        step();
        irq_enable = 1'b1; XB_pc = 32'h600; csr_mtvec = 32'h700; exc_tval = 32'h55;
        sb.push_back(e);
        bump_count();
        step();
        idle_inputs();
        @(negedge clk);
        got = sb.pop_front();
        total++;
        if ({trap_we, trap_mepc, trap_mcause, trap_mtval, mstatus_mie} !==
            {got.trap, got.mepc, got.mcause, got.mtval, 1'b0}) begin
            bad++;
            $display("FAIL irq_trap: got we=%b mepc=%h mcause=%h mtval=%h mie=%b want %b %h %h %h 0",
                     trap_we, trap_mepc, trap_mcause, trap_mtval, mstatus_mie,
                     got.trap, got.mepc, got.mcause, got.mtval);
        end
        @(negedge clk);
        total++;
        if ({redirect_valid, redirect_pc} !== {1'b1, got.pc}) begin
            bad++;
            $display("FAIL irq_redir: got v=%b pc=%h want 1 %h", redirect_valid, redirect_pc, got.pc);
        end
        step();
        XB_bubble = 1'b0; mret = 1'b1; csr_mepc = 32'h600;
        step();
        idle_inputs();
        step();
        step();
        @(negedge clk);
        total++;
        if ({mstatus_mie, trap_count} !== {1'b1, exp_count}) begin
            bad++;
            $display("FAIL irq_mret_restore: got mie=%b cnt=%0d want 1 cnt=%0d",
                     mstatus_mie, trap_count, exp_count);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        XB_pc = '0; exc_cause = '0; exc_tval = '0;
        csr_mtvec = '0; csr_mepc = '0; redirect_ready = 1'b1;
`ifdef TRAP_SEQUENCER_IRQ_EN
        irq_enable = 1'b0;
`endif
        test_reset();
        test_exception();
        test_mret();
        test_priority();
        test_bubble();
        test_back_to_back_ignored();
        test_reset_mid();
        test_saturation();
`ifdef TRAP_SEQUENCER_IRQ_EN
        test_irq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
